// File: rtl/rv32i_ipsend.sv
// Ethernet/IPv4/UDP frame transmitter driving an MII nibble interface.
// One frame per tx_start: header fields from latched inputs, payload from a FWFT FIFO, CRC-32 trailer.
module rv32i_ipsend #(
    parameter logic [15:0] UDP_SRC_PORT = 16'h1F90,
    parameter logic [15:0] UDP_DST_PORT = 16'h1F90,
    parameter int          IFG_BYTES    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [47:0] board_mac,
    input  logic [47:0] pc_mac,
    input  logic [31:0] board_IP,
    input  logic [31:0] pc_IP,
    input  logic [31:0] data_cmd,
    input  logic [15:0] data_len,
    input  logic [31:0] data_i,
    output logic        data_rd,
    output logic [3:0]  dataout,
    output logic        txen,
    output logic        tx_finish,
    output logic [3:0]  state
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, PREAMBLE = 4'd1, SFD = 4'd2, MAC = 4'd3, TYPE = 4'd4, IP_HDR = 4'd5,
        UDP_HDR = 4'd6, CMD = 4'd7, DATA = 4'd8, PAD = 4'd9, FCS = 4'd10, IFG = 4'd11
    } state_t;

    localparam logic [11:0] IFG_LAST = 12'(2 * IFG_BYTES - 1);

    state_t       cur, nxt;
    logic         nib;
    logic [11:0]  cnt;
    logic [31:0]  crc;
    logic [47:0]  dmac_q, smac_q;
    logic [31:0]  sip_q, dip_q, cmd_q;
    logic [11:0]  len_q, pad_q;
    logic [15:0]  dl, tot_len, udp_len;
    logic [11:0]  len_in, pad_in, n_bytes;
    logic [159:0] ip_sh;
    logic [95:0]  mac_sh;
    logic [63:0]  udp_sh;
    logic [31:0]  cmd_sh, dat_sh, fcs_sh;
    logic [7:0]   byte_val;
    logic [3:0]   nib_val;
    logic         active, crc_en, rd_c, fin_c, byte_last;

    function automatic logic [15:0] ip_csum(input logic [15:0] tot, input logic [31:0] sip,
                                            input logic [31:0] dip);
        logic [19:0] s;
        s = 20'h04500 + {4'd0, tot} + 20'h04000 + 20'h08011
          + {4'd0, sip[31:16]} + {4'd0, sip[15:0]} + {4'd0, dip[31:16]} + {4'd0, dip[15:0]};
        s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
        s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
        return ~s[15:0];
    endfunction

    // Reflected CRC-32, one nibble per call, low bit first to match MII bit order.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign dl      = data_len & 16'hFFFC;
    assign len_in  = (dl > 16'd1468) ? 12'd1468 : dl[11:0];
    assign pad_in  = (len_in < 12'd14) ? 12'd14 - len_in : 12'd0;
    assign tot_len = 16'd32 + {4'd0, len_q};
    assign udp_len = 16'd12 + {4'd0, len_q};

    assign ip_sh  = {16'h4500, tot_len, 16'h0000, 16'h4000, 8'h80, 8'h11,
                     ip_csum(tot_len, sip_q, dip_q), sip_q, dip_q} << {cnt, 3'b000};
    assign mac_sh = {dmac_q, smac_q} << {cnt, 3'b000};
    assign udp_sh = {UDP_SRC_PORT, UDP_DST_PORT, udp_len, 16'h0000} << {cnt, 3'b000};
    assign cmd_sh = cmd_q << {cnt[1:0], 3'b000};
    assign dat_sh = data_i << {cnt[1:0], 3'b000};
    assign fcs_sh = ~crc >> {cnt[1:0], nib, 2'b00};

    always_ff @(posedge clk) begin
        if (cur == IDLE && tx_start && !rst) begin
            dmac_q <= pc_mac;
            smac_q <= board_mac;
            sip_q  <= board_IP;
            dip_q  <= pc_IP;
            cmd_q  <= data_cmd;
            len_q  <= len_in;
            pad_q  <= pad_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= IDLE;
            nib <= 1'b0;
            cnt <= 12'd0;
            crc <= 32'hFFFFFFFF;
        end else begin
            cur <= nxt;
            if (cur == IDLE) begin
                nib <= 1'b0;
                cnt <= 12'd0;
                if (tx_start)
                    crc <= 32'hFFFFFFFF;
            end else if (cur == IFG) begin
                nib <= 1'b0;
                cnt <= (cnt == IFG_LAST) ? 12'd0 : cnt + 12'd1;
            end else if (active) begin
                nib <= ~nib;
                if (nib)
                    cnt <= byte_last ? 12'd0 : cnt + 12'd1;
                if (crc_en)
                    crc <= crc_nib(crc, nib_val);
            end else begin
                nib <= 1'b0;
                cnt <= 12'd0;
            end
        end
    end

    always_comb begin
        active   = 1'b0;
        crc_en   = 1'b0;
        rd_c     = 1'b0;
        byte_val = 8'h00;
        n_bytes  = 12'd1;
        case (cur)
            PREAMBLE: begin active = 1'b1; byte_val = 8'h55; n_bytes = 12'd7; end
            SFD:      begin active = 1'b1; byte_val = 8'hD5; end
            MAC:      begin active = 1'b1; crc_en = 1'b1; byte_val = mac_sh[95:88]; n_bytes = 12'd12; end
            TYPE:     begin active = 1'b1; crc_en = 1'b1; byte_val = cnt[0] ? 8'h00 : 8'h08; n_bytes = 12'd2; end
            IP_HDR:   begin active = 1'b1; crc_en = 1'b1; byte_val = ip_sh[159:152]; n_bytes = 12'd20; end
            UDP_HDR:  begin active = 1'b1; crc_en = 1'b1; byte_val = udp_sh[63:56]; n_bytes = 12'd8; end
            CMD:      begin active = 1'b1; crc_en = 1'b1; byte_val = cmd_sh[31:24]; n_bytes = 12'd4; end
            DATA: begin
                active   = 1'b1;
                crc_en   = 1'b1;
                byte_val = dat_sh[31:24];
                n_bytes  = len_q;
                rd_c     = nib && (cnt[1:0] == 2'd3);
            end
            PAD:      begin active = 1'b1; crc_en = 1'b1; n_bytes = pad_q; end
            FCS:      begin active = 1'b1; n_bytes = 12'd4; end
            default:  ;
        endcase
    end

    assign byte_last = nib && (cnt == n_bytes - 12'd1);
    assign nib_val   = (cur == FCS) ? fcs_sh[3:0] : (nib ? byte_val[7:4] : byte_val[3:0]);

    always_comb begin
        nxt   = cur;
        fin_c = 1'b0;
        case (cur)
            IDLE:     if (tx_start) nxt = PREAMBLE;
            PREAMBLE: if (byte_last) nxt = SFD;
            SFD:      if (byte_last) nxt = MAC;
            MAC:      if (byte_last) nxt = TYPE;
            TYPE:     if (byte_last) nxt = IP_HDR;
            IP_HDR:   if (byte_last) nxt = UDP_HDR;
            UDP_HDR:  if (byte_last) nxt = CMD;
            CMD:      if (byte_last) nxt = (len_q != 12'd0) ? DATA : ((pad_q != 12'd0) ? PAD : FCS);
            DATA:     if (byte_last) nxt = (pad_q != 12'd0) ? PAD : FCS;
            PAD:      if (byte_last) nxt = FCS;
            FCS:      if (byte_last) nxt = IFG;
            IFG: begin
                fin_c = (cnt == IFG_LAST);
                if (fin_c) nxt = IDLE;
            end
            default:  nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet combinationally while reset is held.
    assign txen      = active & ~rst;
    assign dataout   = (active & ~rst) ? nib_val : 4'd0;
    assign data_rd   = rd_c & ~rst;
    assign tx_finish = fin_c & ~rst;
    assign state     = cur;
endmodule

// File: tb/tb_rv32i_ipsend.sv
// Directed bench for rv32i_ipsend: captures the MII nibble stream into bytes and checks frames.
module tb_rv32i_ipsend;
    logic        clk = 1'b0;
    logic        rst, tx_start, data_rd, txen, tx_finish, fifo_clr;
    logic [47:0] board_mac, pc_mac;
    logic [31:0] board_IP, pc_IP, data_cmd, data_i;
    logic [15:0] data_len;
    logic [3:0]  dataout, state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32i_ipsend dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .board_mac(board_mac), .pc_mac(pc_mac),
        .board_IP(board_IP), .pc_IP(pc_IP), .data_cmd(data_cmd), .data_len(data_len),
        .data_i(data_i), .data_rd(data_rd), .dataout(dataout), .txen(txen),
        .tx_finish(tx_finish), .state(state)
    );

    // FWFT FIFO model
    logic [31:0] fifo_mem [0:511];
    int fifo_ptr = 0;
    always @(posedge clk) begin
        if (fifo_clr) fifo_ptr <= 0;
        else if (data_rd) fifo_ptr <= fifo_ptr + 1;
    end
    assign data_i = fifo_mem[fifo_ptr[8:0]];

    // Nibble-to-byte capture and event counters
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [3:0] lo_nib;
    bit half, txen_d;
    int rd_cnt, fin_cnt, frames, ifg_cnt, ifg_bad;

    initial begin
        half = 0; txen_d = 0;
        forever begin
            @(negedge clk);
            if (txen === 1'b1) begin
                if (!txen_d) frames++;
                if (half) cap.push_back({dataout, lo_nib});
                else lo_nib = dataout;
                half = ~half;
            end else half = 0;
            if (state == 4'd11) begin
                ifg_cnt++;
                if (dataout !== 4'd0 || txen !== 1'b0) ifg_bad++;
            end
            if (data_rd === 1'b1) rd_cnt++;
            if (tx_finish === 1'b1) fin_cnt++;
            txen_d = (txen === 1'b1);
        end
    end

    function automatic logic [31:0] crc_q(input logic [7:0] q[$], input int from, input int to);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = from; i <= to; i++) begin
            c = c ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) return i;
        if (cap.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    // Reference frame built from the current inputs and FIFO contents; len/pad are hand-derived by caller.
    task automatic build_exp(input int len, input int pad);
        logic [15:0] w [10];
        logic [31:0] s, fcs;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(pc_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(board_mac[8*i +: 8]);
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        w = '{16'h4500, 16'(32 + len), 16'h0000, 16'h4000, 16'h8011, 16'h0000,
              board_IP[31:16], board_IP[15:0], pc_IP[31:16], pc_IP[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s = s + {16'd0, w[i]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        w[5] = ~s[15:0];
        for (int i = 0; i < 10; i++) begin exp_q.push_back(w[i][15:8]); exp_q.push_back(w[i][7:0]); end
        w[0] = 16'h1F90; w[1] = 16'h1F90; w[2] = 16'(12 + len); w[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin exp_q.push_back(w[i][15:8]); exp_q.push_back(w[i][7:0]); end
        for (int i = 3; i >= 0; i--) exp_q.push_back(data_cmd[8*i +: 8]);
        for (int k = 0; k < len / 4; k++)
            for (int i = 3; i >= 0; i--) exp_q.push_back(fifo_mem[k][8*i +: 8]);
        repeat (pad) exp_q.push_back(8'h00);
        fcs = crc_q(exp_q, 8, exp_q.size() - 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    task automatic prep();
        @(posedge clk); #1 fifo_clr = 1;
        @(posedge clk); #1 fifo_clr = 0;
        cap.delete();
        rd_cnt = 0; fin_cnt = 0; frames = 0; ifg_cnt = 0; ifg_bad = 0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1 tx_start = 1;
        @(posedge clk); #1 tx_start = 0;
    endtask

    task automatic wait_finish(input int budget);
        for (int i = 0; i < budget && fin_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (fin_cnt == 0) begin
            n_fail++;
            $display("FAIL timeout: no tx_finish within %0d cycles (got 0, want 1)", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1; tx_start = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++;
        if (txen !== 1'b0) begin n_fail++; $display("FAIL reset_txen: got %b want 0", txen); end
        n_checks++;
        if ({dataout, data_rd, tx_finish} !== 6'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0", dataout, data_rd, tx_finish);
        end
        rst = 0;
    endtask

    task automatic test_zero_len();
        int d;
        pc_mac = 48'h001122334455; board_mac = 48'h0A0B0C0D0E0F;
        board_IP = 32'hC0A80002; pc_IP = 32'hC0A80003; data_cmd = 32'h00000001; data_len = 16'd0;
        prep();
        build_exp(0, 14);
        start_frame();
        n_checks++;
        if (txen !== 1'b1 || state !== 4'd1 || dataout !== 4'h5) begin
            n_fail++; $display("FAIL zero_start: got txen=%b state=%0d nib=%h want 1/1/5", txen, state, dataout);
        end
        wait_finish(400);
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL zero_stream: byte %0d got %h want %h", d, cap[d], exp_q[d]); end
        n_checks++;
        if (cap.size() != 72) begin n_fail++; $display("FAIL zero_size: got %0d want 72", cap.size()); end
        n_checks++;
        if ({cap[24], cap[25]} !== 16'h0020) begin n_fail++; $display("FAIL zero_total_len: got %h want 0020", {cap[24], cap[25]}); end
        n_checks++;
        if ({cap[46], cap[47]} !== 16'h000C) begin n_fail++; $display("FAIL zero_udp_len: got %h want 000c", {cap[46], cap[47]}); end
        n_checks++;
        if ({cap[50], cap[51], cap[52], cap[53]} !== 32'h00000001) begin
            n_fail++; $display("FAIL zero_cmd: got %h want 00000001", {cap[50], cap[51], cap[52], cap[53]});
        end
        n_checks++;
        if (rd_cnt != 0) begin n_fail++; $display("FAIL zero_rd: got %0d want 0", rd_cnt); end
        n_checks++;
        if (ifg_cnt != 24 || ifg_bad != 0 || fin_cnt != 1 || frames != 1) begin
            n_fail++; $display("FAIL zero_ifg: got ifg=%0d bad=%0d fin=%0d frames=%0d want 24/0/1/1", ifg_cnt, ifg_bad, fin_cnt, frames);
        end
    endtask

    task automatic test_data16();
        int d;
        fifo_mem[0] = 32'h11223344; fifo_mem[1] = 32'h55667788;
        fifo_mem[2] = 32'h99AABBCC; fifo_mem[3] = 32'hDDEEFF00;
        data_len = 16'd16; data_cmd = 32'hA5A5_0102;
        prep();
        build_exp(16, 0);
        start_frame();
        wait_finish(400);
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL d16_stream: byte %0d got %h want %h", d, cap[d], exp_q[d]); end
        n_checks++;
        if ({cap[54], cap[55], cap[56], cap[57], cap[58]} !== 40'h1122334455) begin
            n_fail++; $display("FAIL d16_order: got %h want 1122334455", {cap[54], cap[55], cap[56], cap[57], cap[58]});
        end
        n_checks++;
        if (rd_cnt != 4 || cap.size() != 74) begin
            n_fail++; $display("FAIL d16_rd_size: got rd=%0d size=%0d want 4/74", rd_cnt, cap.size());
        end
        n_checks++;
        if ({cap[73], cap[72], cap[71], cap[70]} !== crc_q(cap, 8, 69)) begin
            n_fail++; $display("FAIL d16_fcs: got %h want %h", {cap[73], cap[72], cap[71], cap[70]}, crc_q(cap, 8, 69));
        end
    endtask

    task automatic test_ip_checksum();
        int d;
        logic [31:0] s;
        board_IP = 32'hC0A80002; pc_IP = 32'hC0A80003; data_len = 16'd8;
        prep();
        build_exp(8, 6);
        start_frame();
        wait_finish(400);
        n_checks++;
        if ({cap[32], cap[33]} !== 16'h796F) begin n_fail++; $display("FAIL ip_csum: got %h want 796f", {cap[32], cap[33]}); end
        s = 0;
        for (int i = 0; i < 10; i++) s = s + {16'd0, cap[22+2*i], cap[23+2*i]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        n_checks++;
        if (s[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL ip_sum: got %h want ffff", s[15:0]); end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL ip_stream: byte %0d got %h want %h", d, cap[d], exp_q[d]); end
    endtask

    task automatic test_clamp();
        int d;
        for (int k = 0; k < 512; k++) fifo_mem[k] = {8'(k), ~8'(k), 8'h5A, 8'(k >> 8)};
        data_len = 16'd2000;
        prep();
        build_exp(1468, 0);
        start_frame();
        wait_finish(4000);
        n_checks++;
        if ({cap[24], cap[25]} !== 16'h05DC || {cap[46], cap[47]} !== 16'h05C8) begin
            n_fail++; $display("FAIL clamp_len: got %h/%h want 05dc/05c8", {cap[24], cap[25]}, {cap[46], cap[47]});
        end
        n_checks++;
        if (rd_cnt != 367) begin n_fail++; $display("FAIL clamp_rd: got %0d want 367", rd_cnt); end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL clamp_stream: byte %0d got %h want %h", d, cap[d], exp_q[d]); end
        data_len = 16'd7;
        prep();
        build_exp(4, 10);
        start_frame();
        wait_finish(400);
        n_checks++;
        if ({cap[24], cap[25]} !== 16'h0024 || rd_cnt != 1 || cap.size() != 72) begin
            n_fail++; $display("FAIL len7: got total=%h rd=%0d size=%0d want 0024/1/72", {cap[24], cap[25]}, rd_cnt, cap.size());
        end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL len7_stream: byte %0d got %h want %h", d, cap[d], exp_q[d]); end
    endtask

    task automatic test_reset_mid();
        int d;
        bit seen;
        fifo_mem[0] = 32'h11223344; fifo_mem[1] = 32'h55667788;
        fifo_mem[2] = 32'h99AABBCC; fifo_mem[3] = 32'hDDEEFF00;
        data_len = 16'd16;
        prep();
        start_frame();
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin @(posedge clk); #1; seen = (state == 4'd8); end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rstmid_reach: DATA state not reached (got %0d want 8)", state); end
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        n_checks++;
        if (txen !== 1'b0 || state !== 4'd0 || data_rd !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop: got txen=%b state=%0d rd=%b want 0/0/0", txen, state, data_rd);
        end
        @(posedge clk); #1 rst = 0;
        prep();
        n_checks++;
        if (txen !== 1'b0 || state !== 4'd0) begin
            n_fail++; $display("FAIL rstmid_no_resume: got txen=%b state=%0d want 0/0", txen, state);
        end
        build_exp(16, 0);
        start_frame();
        wait_finish(400);
        d = first_diff();
        n_checks++;
        if (d >= 0 || rd_cnt != 4) begin
            n_fail++; $display("FAIL rstmid_frame: diff at %0d rd=%0d want -1/4", d, rd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        bit seen;
        data_len = 16'd8; pc_mac = 48'h001122334455; data_cmd = 32'hCAFE0001;
        prep();
        build_exp(8, 6);
        @(posedge clk); #1 tx_start = 1;
        @(posedge clk); #1;
        pc_mac = 48'hFFEEDDCCBBAA; data_cmd = 32'h12345678; data_len = 16'd40;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin @(posedge clk); #1; seen = (state == 4'd11); end
        tx_start = 0;
        wait_finish(100);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (frames != 1 || fin_cnt != 1 || ifg_cnt != 24 || state !== 4'd0) begin
            n_fail++; $display("FAIL held_once: got frames=%0d fin=%0d ifg=%0d state=%0d want 1/1/24/0", frames, fin_cnt, ifg_cnt, state);
        end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL held_latched: byte %0d got %h want %h", d, cap[d], exp_q[d]); end
        prep();
        build_exp(40, 0);
        start_frame();
        wait_finish(400);
        d = first_diff();
        n_checks++;
        if (d >= 0 || frames != 1 || rd_cnt != 10) begin
            n_fail++; $display("FAIL next_frame: diff at %0d frames=%0d rd=%0d want -1/1/10", d, frames, rd_cnt);
        end
    endtask

    initial begin
        rst = 1; tx_start = 0; fifo_clr = 1;
        board_mac = 48'h0A0B0C0D0E0F; pc_mac = 48'h001122334455;
        board_IP = 32'hC0A80002; pc_IP = 32'hC0A80003; data_cmd = 32'h1; data_len = 16'd0;
        for (int k = 0; k < 512; k++) fifo_mem[k] = 32'h0;
        test_reset();
        test_zero_len();
        test_data16();
        test_ip_checksum();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_ipsend.md
RV32I_IPSEND -- requirements
Module: rv32i_ipsend

Interface
REQ-001 Parameter: UDP_SRC_PORT, 16'h1F90, board UDP source port.
REQ-002 Parameter: UDP_DST_PORT, 16'h1F90, PC UDP destination port.
REQ-003 Parameter: IFG_BYTES, 12, inter-frame gap length in bytes after the FCS.
REQ-004 Port: clk  in  1  single clock; all logic on posedge; MII TX clock domain.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: tx_start  in  1  one-cycle frame request; sampled only in IDLE.
REQ-007 Port: board_mac / pc_mac  in  48 each  source / destination MAC.
REQ-008 Port: board_IP / pc_IP  in  32 each  source / destination IPv4 address.
REQ-009 Port: data_cmd  in  32  4-byte command header, first UDP payload word.
REQ-010 Port: data_len  in  16  payload bytes following data_cmd.
REQ-011 Port: data_i  in  32  first-word-fall-through FIFO word; valid whenever data_rd would pop it.
REQ-012 Port: data_rd  out  1  one-cycle FIFO pop.
REQ-013 Port: dataout  out  4  MII TXD nibble.
REQ-014 Port: txen  out  1  MII TX_EN.
REQ-015 Port: tx_finish  out  1  one-cycle pulse; frame and IFG complete.
REQ-016 Port: state  out  4  current FSM state encoding.

Function
REQ-017 Frame order SHALL be: 7x 0x55, 0xD5, pc_mac, board_mac, 0x0800, 20-byte IP header, 8-byte UDP header, data_cmd, data words, zero pad, 4-byte FCS; multi-byte fields big-endian.
REQ-018 Each byte SHALL be driven over two consecutive cycles, low nibble first; txen high on every cycle from the first preamble nibble through the last FCS nibble, with no gaps.
REQ-019 On tx_start in IDLE, the block SHALL latch all MAC/IP/cmd/len inputs, and txen SHALL rise on the next cycle.
REQ-020 Latched inputs SHALL NOT change mid-frame; tx_start outside IDLE SHALL be ignored.
REQ-021 Effective length: L = data_len with bits[1:0] cleared, clamped to 1468.
REQ-022 IP header SHALL be: 45 00, total_len = 32+L, 0000, 4000, TTL 80, proto 11, checksum, board_IP, pc_IP.
REQ-023 IP checksum SHALL be the ones-complement of the ones-complement 16-bit sum of the other 9 header words, with end-around carry; it SHALL be complete before the IP header starts (computed during preamble).
REQ-024 UDP header SHALL be: UDP_SRC_PORT, UDP_DST_PORT, udp_len = 12+L, checksum 0000.
REQ-025 Data words SHALL be sent MSB byte first, L/4 words total.
REQ-026 data_rd SHALL pulse on the last nibble cycle of each data word, exactly L/4 pulses per frame.
REQ-027 If 4+L < 18, the block SHALL send 18-(4+L) zero pad bytes, not counted in any length field.
REQ-028 FCS SHALL be Ethernet CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement) over destination MAC through the last pad/data byte, updated per nibble, sent LSB nibble first.
REQ-029 FSM states SHALL be: IDLE=0, PREAMBLE=1, SFD=2, MAC=3, TYPE=4, IP_HDR=5, UDP_HDR=6, CMD=7, DATA=8, PAD=9, FCS=10, IFG=11.
REQ-030 Transitions: CMD->DATA if L>0, else PAD if pad>0, else FCS; DATA->PAD/FCS likewise; FCS->IFG; IFG (2*IFG_BYTES cycles, txen=0, dataout=0)->IDLE, with tx_finish pulsing on the last IFG cycle.
REQ-031 Illegal state encodings SHALL go to IDLE next cycle with txen=0.

Reset
REQ-032 While rst is high, the block SHALL hold state=IDLE, txen=0, dataout=0, data_rd=0, tx_finish=0, and clear the CRC and counters.
REQ-033 rst mid-frame SHALL drop txen on the next edge, and the partial frame SHALL NOT be resumed; the first tx_start after rst release SHALL be honoured.

Verification
REQ-034 L=0, cmd=0x00000001 -> 60-byte frame + FCS, 14 pad bytes, total_len=0x0020, udp_len=0x000C, 0 data_rd pulses.
REQ-035 data_len=16, data_i words 0x11223344.. -> byte stream 11 22 33 44 ..., 4 data_rd pulses, no pad, FCS matches the reference CRC model.
REQ-036 board_IP=192.168.0.2, pc_IP=192.168.0.3, L=8 -> the IP checksum field makes the 16-bit ones-complement header sum equal 0xFFFF.
REQ-037 data_len=2000 -> L=1468, total_len=0x05DC, 367 data_rd pulses; data_len=7 -> L=4.
REQ-038 rst asserted during DATA -> txen=0 next cycle, state=0; new tx_start produces a complete, correct frame.
REQ-039 tx_start held high during a frame -> exactly one frame, tx_finish pulses once after 24 IFG cycles, then the next frame starts on the following tx_start.
